multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction bits [31:26], taken from the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag from the current cycle.
REQ-005 SHALL have 1-bit outputs mem_read, mem_write, ir_write, reg_write, i_or_d, alu_src_a and pc_load.
REQ-006 SHALL have 2-bit outputs alu_src_b, alu_op, pc_src, reg_dst and mem_to_reg.
REQ-007 SHALL have port illegal_op, output, 1 bit: one-cycle pulse when an unsupported opcode is decoded.
REQ-008 SHALL have parameters R_OP=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, J=000010 and JAL=000011.

Function
REQ-009 SHALL be a Moore FSM: state register on clk; every output is decoded from state only, except pc_load and illegal_op, which also use zero and opcode.
REQ-010 SHALL implement the states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP and JAL_WB.
REQ-011 SHALL in FETCH drive mem_read=1, ir_write=1, i_or_d=0, alu_src_a=0, alu_src_b=01 (+4), alu_op=00, pc_src=00 and pc_load=1, then go to DECODE.
REQ-012 SHALL in DECODE drive alu_src_a=0, alu_src_b=11 (sign-extended offset shifted left 2) and alu_op=00, which precomputes the branch target.
REQ-013 SHALL in DECODE branch on opcode: LW/SW->MEM_ADDR, R_OP->R_EXEC, BEQ/BNE->BRANCH, ADDI->ADDI_EXEC, J->JUMP, JAL->JAL_WB.
REQ-014 SHALL in DECODE, for any other opcode, go to FETCH and pulse illegal_op=1 for that cycle.
REQ-015 SHALL in MEM_ADDR drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD if opcode=LW, else to MEM_WR.
REQ-016 SHALL in MEM_RD drive mem_read=1 and i_or_d=1, then go to MEM_WB.
REQ-017 SHALL in MEM_WB drive reg_write=1, reg_dst=00 (rt) and mem_to_reg=01, then go to FETCH.
REQ-018 SHALL in MEM_WR drive mem_write=1 and i_or_d=1, then go to FETCH.
REQ-019 SHALL in R_EXEC drive alu_src_a=1, alu_src_b=00 and alu_op=10 (RTYPE; function field decoded downstream), then go to R_WB.
REQ-020 SHALL in R_WB drive reg_write=1, reg_dst=01 (rd) and mem_to_reg=00, then go to FETCH.
REQ-021 SHALL in BRANCH drive alu_src_a=1, alu_src_b=00, alu_op=01 and pc_src=01, then go to FETCH.
REQ-022 SHALL in BRANCH compute pc_load = zero for BEQ and ~zero for BNE.
REQ-023 SHALL in ADDI_EXEC drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to ADDI_WB.
REQ-024 SHALL in ADDI_WB drive reg_write=1, reg_dst=00 and mem_to_reg=00, then go to FETCH.
REQ-025 SHALL in JUMP drive pc_src=10 and pc_load=1, then go to FETCH.
REQ-026 SHALL in JAL_WB drive reg_write=1, reg_dst=10 ($31), mem_to_reg=10 (PC), pc_src=10 and pc_load=1, then go to FETCH.
REQ-027 SHALL drive 0 on every output not listed for the current state.
REQ-028 SHALL take these cycle counts per instruction: LW 5; SW, R-type and ADDI 4; branch 3; J and JAL 3.
REQ-029 SHALL read opcode only in DECODE and MEM_ADDR, and SHALL ignore opcode changes in all other states.
REQ-030 SHALL recover to FETCH on the next edge from an unreachable state encoding, with all outputs 0 for that cycle.

Reset
REQ-031 SHALL force state to FETCH asynchronously while rst=1.
REQ-032 SHALL hold pc_load, ir_write, mem_write, reg_write and illegal_op at 0 while rst=1, with the gating combinational on rst.
REQ-033 SHALL treat an rst assertion mid-instruction as an abort: no write strobe is issued after the assertion, and FETCH begins on the first edge after deassertion.

Structure
REQ-034 SHALL put the alu_op encodings (00 MTYPE, 01 BTYPE, 10 RTYPE, 11 JTYPE) and the state encodings in constant_values.h, shared with the ALU controller.
REQ-035 SHALL be one module with no sub-modules: next-state logic and output decode in separate combinational blocks.

Verification
REQ-036 SHALL cover LW (opcode=100011): reset, release -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 and mem_to_reg=01 only in cycle 5.
REQ-037 SHALL cover BEQ (000100): zero=1 -> pc_load=1 and pc_src=01 in cycle 3; zero=0 -> pc_load=0 in cycle 3.
REQ-038 SHALL cover BNE (000101) with zero=0 -> pc_load=1 in cycle 3.
REQ-039 SHALL cover the illegal opcode 111111 -> illegal_op=1 in the DECODE cycle, FETCH on the next cycle, and no write strobe.
REQ-040 SHALL cover SW (101011) with rst asserted in MEM_ADDR -> mem_write stays 0, state=FETCH immediately, and no strobes while rst=1.
REQ-041 SHALL cover JAL (000011) -> cycle 3 has reg_write=1, reg_dst=10, mem_to_reg=10 and pc_load=1.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_cycle_controller_pkg: state, ALU-op and mux-select encodings   |
// | shared by the multi-cycle controller and the ALU controller. Rev 1.0 |
// +----------------------------------------------------------------------+
package multi_cycle_controller_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_RD    = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WR    = 4'd5;
  localparam logic [STATE_W-1:0] S_R_EXEC    = 4'd6;
  localparam logic [STATE_W-1:0] S_R_WB      = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH    = 4'd8;
  localparam logic [STATE_W-1:0] S_ADDI_EXEC = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDI_WB   = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP      = 4'd11;
  localparam logic [STATE_W-1:0] S_JAL_WB    = 4'd12;

  localparam logic [1:0] ALU_MTYPE = 2'b00;
  localparam logic [1:0] ALU_BTYPE = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_JTYPE = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BR_OFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic       pc_load;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_cycle_controller: Moore FSM sequencing a multi-cycle MIPS      |
// | datapath (fetch/decode/execute/writeback).                 Rev 1.0  |
// +----------------------------------------------------------------------+
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter logic [5:0] R_OP = 6'b000000,
  parameter logic [5:0] LW   = 6'b100011,
  parameter logic [5:0] SW   = 6'b101011,
  parameter logic [5:0] BEQ  = 6'b000100,
  parameter logic [5:0] BNE  = 6'b000101,
  parameter logic [5:0] ADDI = 6'b001000,
  parameter logic [5:0] J    = 6'b000010,
  parameter logic [5:0] JAL  = 6'b000011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic       pc_load,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state_q, state_d;
  // Branch flavour is captured in DECODE so BRANCH never has to look at opcode.
  logic               is_bne_q, is_bne_d;
  logic               op_known;
  ctrl_t              ctrl;

  assign op_known = (opcode == R_OP) || (opcode == LW)  || (opcode == SW) ||
                    (opcode == BEQ)  || (opcode == BNE) || (opcode == ADDI) ||
                    (opcode == J)    || (opcode == JAL);

  always_comb begin
    state_d  = S_FETCH;
    is_bne_d = is_bne_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        is_bne_d = (opcode == BNE);
        if ((opcode == LW) || (opcode == SW))        state_d = S_MEM_ADDR;
        else if (opcode == R_OP)                     state_d = S_R_EXEC;
        else if ((opcode == BEQ) || (opcode == BNE)) state_d = S_BRANCH;
        else if (opcode == ADDI)                     state_d = S_ADDI_EXEC;
        else if (opcode == J)                        state_d = S_JUMP;
        else if (opcode == JAL)                      state_d = S_JAL_WB;
        else                                         state_d = S_FETCH;
      end
      S_MEM_ADDR:  state_d = (opcode == LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_MTYPE;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_load   = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_BR_OFF;
        ctrl.alu_op     = ALU_MTYPE;
        ctrl.illegal_op = ~op_known;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_MTYPE;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_MEM;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_BTYPE;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_load   = is_bne_q ? ~zero : zero;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_ALU;
      end
      S_JUMP: begin
        ctrl.pc_src  = PCSRC_JUMP;
        ctrl.pc_load = 1'b1;
      end
      S_JAL_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_load    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Architectural side-effect strobes are killed combinationally while reset is held.
  assign pc_load    = ctrl.pc_load    & ~rst;
  assign ir_write   = ctrl.ir_write   & ~rst;
  assign mem_write  = ctrl.mem_write  & ~rst;
  assign reg_write  = ctrl.reg_write  & ~rst;
  assign illegal_op = ctrl.illegal_op & ~rst;

  assign mem_read   = ctrl.mem_read;
  assign i_or_d     = ctrl.i_or_d;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_multi_cycle_controller: directed + random instruction streams     |
// | checked against a per-instruction/per-cycle control table. Rev 1.0  |
// +----------------------------------------------------------------------+
module tb_multi_cycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_read, mem_write, ir_write, reg_write, i_or_d, alu_src_a, pc_load;
  logic [1:0] alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  logic [5:0] legal_ops [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL};

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
    .pc_load(pc_load), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_read, mem_write, ir_write, reg_write, i_or_d, alu_src_a,
                pc_load, illegal_op, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg};

  function automatic logic [17:0] mk(input bit mr, mw, irw, rw, iod, asa, pcl, ill,
                                     input bit [1:0] asb, aop, psrc, rdst, m2r);
    return {mr, mw, irw, rw, iod, asa, pcl, ill, asb, aop, psrc, rdst, m2r};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int n_cycles(input logic [5:0] op);
    case (op)
      OP_LW:                       return 5;
      OP_SW, OP_R, OP_ADDI:        return 4;
      OP_BEQ, OP_BNE, OP_J, OP_JAL: return 3;
      default:                     return 2;
    endcase
  endfunction

  // Expected control word for cycle c (1-based) of an instruction with opcode op.
  function automatic logic [17:0] expect_cw(input logic [5:0] op, input int c, input bit z);
    if (c == 1) return mk(1,0,1,0,0,0,1,0, 2'b01,2'b00,2'b00,2'b00,2'b00);
    if (c == 2) return mk(0,0,0,0,0,0,0,!is_legal(op), 2'b11,2'b00,2'b00,2'b00,2'b00);
    case (op)
      OP_LW: begin
        if (c == 3) return mk(0,0,0,0,0,1,0,0, 2'b10,2'b00,2'b00,2'b00,2'b00);
        if (c == 4) return mk(1,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
        return mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01);
      end
      OP_SW: begin
        if (c == 3) return mk(0,0,0,0,0,1,0,0, 2'b10,2'b00,2'b00,2'b00,2'b00);
        return mk(0,1,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
      end
      OP_R: begin
        if (c == 3) return mk(0,0,0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b00,2'b00);
        return mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00);
      end
      OP_ADDI: begin
        if (c == 3) return mk(0,0,0,0,0,1,0,0, 2'b10,2'b00,2'b00,2'b00,2'b00);
        return mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
      end
      OP_BEQ:  return mk(0,0,0,0,0,1, z,0, 2'b00,2'b01,2'b01,2'b00,2'b00);
      OP_BNE:  return mk(0,0,0,0,0,1,!z,0, 2'b00,2'b01,2'b01,2'b00,2'b00);
      OP_J:    return mk(0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b10,2'b00,2'b00);
      OP_JAL:  return mk(0,0,0,1,0,0,1,0, 2'b00,2'b00,2'b10,2'b10,2'b10);
      default: return '0;
    endcase
  endfunction

  // FETCH decode with every reset-gated strobe forced low.
  logic [17:0] rst_cw;
  initial rst_cw = mk(1,0,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00);

  task automatic check(input string tag, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Entered and left at 1ns after a rising edge, with the FSM in FETCH.
  // zmode < 0 randomizes zero each cycle; opcode is only stable where it is sampled.
  task automatic run_instr(input logic [5:0] op, input int zmode, input string tag);
    int n;
    n = n_cycles(op);
    for (int c = 1; c <= n; c++) begin
      zero = (zmode < 0) ? 1'($urandom) : zmode[0];
      if (c == 2 || (c == 3 && (op == OP_LW || op == OP_SW))) opcode = op;
      else opcode = 6'($urandom);
      #2;
      check($sformatf("%s op=%b c%0d", tag, op, c), expect_cw(op, c, zero));
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] rop;

  initial begin
    rst = 1'b1; opcode = 6'b0; zero = 1'b0;
    #2 check("reset_state", rst_cw);
    @(posedge clk); #1;
    opcode = OP_SW;
    #2 check("reset_held", rst_cw);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(OP_LW,  -1, "lw");
    run_instr(OP_BEQ,  1, "beq_taken");
    run_instr(OP_BEQ,  0, "beq_not_taken");
    run_instr(OP_BNE,  0, "bne_taken");
    run_instr(OP_BNE,  1, "bne_not_taken");
    run_instr(6'b111111, -1, "illegal");
    run_instr(OP_JAL, -1, "jal");

    // SW aborted by reset in MEM_ADDR
    for (int c = 1; c <= 2; c++) begin
      opcode = OP_SW; zero = 1'($urandom);
      #2 check($sformatf("sw_abort c%0d", c), expect_cw(OP_SW, c, zero));
      @(posedge clk); #1;
    end
    opcode = OP_SW;
    #2 check("sw_abort mem_addr", expect_cw(OP_SW, 3, zero));
    #1 rst = 1'b1;
    #1 check("sw_abort rst_async", rst_cw);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      opcode = 6'($urandom); zero = 1'($urandom);
      #2 check($sformatf("sw_abort rst_hold%0d", c), rst_cw);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(OP_R, -1, "after_abort");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0) begin
        rop = 6'($urandom);
      end else begin
        rop = legal_ops[$urandom_range(7)];
      end
      run_instr(rop, -1, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not finish within 100000ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
